// File: rtl/goertzel_bank.sv
// Time-multiplexed Goertzel filter bank: one shared multiplier walks all bins per
// sample, states are rescaled periodically and dumped/cleared at every block end.
module goertzel_bank #(
    parameter int N_CH       = 4,
    parameter int DW         = 16,
    parameter int COEFF_BITS = 18,
    parameter logic [N_CH*COEFF_BITS-1:0] COEFFS = '0,
    parameter int BLOCK_POW2 = 8,
    parameter int SCALE_POW2 = 4,
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHW-1:0]         out_ch,
    output logic signed [DW+1:0]   out_s0,
    output logic signed [DW+1:0]   out_s1,
    output logic [BLOCK_POW2-1:0]  count_o
);

    localparam int IW = DW + SCALE_POW2 + 1;
    localparam int PW = IW + COEFF_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;
    localparam logic [1:0] S_DUMP  = 2'd3;

    localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);

    logic [1:0]            state_q, state_d;
    logic [CHW-1:0]        chan_q, chan_d;
    logic [BLOCK_POW2-1:0] count_q, count_d;
    logic signed [DW-1:0]  sample_q, sample_d;
    logic signed [IW-1:0]  s0_q [N_CH];
    logic signed [IW-1:0]  s1_q [N_CH];
    logic signed [IW-1:0]  s0_d [N_CH];
    logic signed [IW-1:0]  s1_d [N_CH];

    logic signed [COEFF_BITS-1:0] coeffSel;
    logic signed [IW-1:0]         s0Sel, s1Sel, prodTrunc, s0New;
    logic signed [PW-1:0]         prodFull;

    // Shared datapath: operands are sign-extended to the full product width so the
    // wrapped product is exact before the fixed-point shift and truncation.
    always_comb begin
        coeffSel  = COEFFS[int'(chan_q) * COEFF_BITS +: COEFF_BITS];
        s0Sel     = s0_q[chan_q];
        s1Sel     = s1_q[chan_q];
        prodFull  = $signed({{COEFF_BITS{s0Sel[IW-1]}}, s0Sel})
                  * $signed({{IW{coeffSel[COEFF_BITS-1]}}, coeffSel});
        prodTrunc = IW'(prodFull >>> (COEFF_BITS - 2));
        s0New     = {{(IW-DW){sample_q[DW-1]}}, sample_q} + prodTrunc - s1Sel;
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        count_d  = count_q;
        sample_d = sample_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        if (clr_i) begin
            state_d  = S_IDLE;
            chan_d   = '0;
            count_d  = '0;
            sample_d = '0;
            for (int k = 0; k < N_CH; k++) begin
                s0_d[k] = '0;
                s1_d[k] = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sample_d = in_data;
                        chan_d   = '0;
                        state_d  = S_CALC;
                    end
                end
                S_CALC: begin
                    s0_d[chan_q] = s0New;
                    s1_d[chan_q] = s0Sel;
                    if (chan_q == LAST_CH) begin
                        chan_d  = '0;
                        count_d = count_q + BLOCK_POW2'(1);
                        state_d = (&count_q[SCALE_POW2-1:0]) ? S_SCALE : S_IDLE;
                    end else begin
                        chan_d = chan_q + CHW'(1);
                    end
                end
                S_SCALE: begin
                    for (int k = 0; k < N_CH; k++) begin
                        s0_d[k] = s0_q[k] >>> (SCALE_POW2 - 1);
                        s1_d[k] = s1_q[k] >>> (SCALE_POW2 - 1);
                    end
                    // The counter only wraps on a scale point, so zero here marks block end.
                    state_d = (count_q == '0) ? S_DUMP : S_IDLE;
                end
                S_DUMP: begin
                    if (out_ready) begin
                        if (chan_q == LAST_CH) begin
                            chan_d  = '0;
                            count_d = '0;
                            state_d = S_IDLE;
                            for (int k = 0; k < N_CH; k++) begin
                                s0_d[k] = '0;
                                s1_d[k] = '0;
                            end
                        end else begin
                            chan_d = chan_q + CHW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            chan_q   <= '0;
            count_q  <= '0;
            sample_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
                s0_q[k] <= '0;
                s1_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            count_q  <= count_d;
            sample_q <= sample_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DUMP);
    assign out_ch    = out_valid ? chan_q : '0;
    assign out_s0    = out_valid ? s0Sel[DW+1:0] : '0;
    assign out_s1    = out_valid ? s1Sel[DW+1:0] : '0;
    assign count_o   = count_q;

endmodule

// File: tb/tb_goertzel_bank.sv
// Self-checking bench for goertzel_bank: random and directed sample blocks are
// compared against an arithmetic reference of the recursion, scaling and dump.
module tb_goertzel_bank;

    localparam int N_CH       = 3;
    localparam int DW         = 8;
    localparam int COEFF_BITS = 18;
    localparam int BLOCK_POW2 = 4;
    localparam int SCALE_POW2 = 2;
    localparam int CHW        = 2;
    localparam int IW         = DW + SCALE_POW2 + 1;
    localparam int SCALE_LEN  = 1 << SCALE_POW2;
    localparam int BLOCK_LEN  = 1 << BLOCK_POW2;
    localparam logic [N_CH*COEFF_BITS-1:0] COEFFS = {18'h28000, 18'h00000, 18'h10000};
    localparam int COEFF_VAL [N_CH] = '{65536, 0, -98304};

    logic                  clk;
    logic                  rstN;
    logic                  clrI;
    logic                  inValid;
    logic                  inReady;
    logic signed [DW-1:0]  inData;
    logic                  outValid;
    logic                  outReady;
    logic [CHW-1:0]        outCh;
    logic signed [DW+1:0]  outS0;
    logic signed [DW+1:0]  outS1;
    logic [BLOCK_POW2-1:0] countO;

    int checks = 0;
    int errors = 0;

    longint ms0 [N_CH];
    longint ms1 [N_CH];
    int     mCount;

    goertzel_bank #(
        .N_CH(N_CH), .DW(DW), .COEFF_BITS(COEFF_BITS), .COEFFS(COEFFS),
        .BLOCK_POW2(BLOCK_POW2), .SCALE_POW2(SCALE_POW2)
    ) dut (
        .clk(clk), .rst_n(rstN), .clr_i(clrI),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_ch(outCh),
        .out_s0(outS0), .out_s1(outS1), .count_o(countO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint wrapTo(input longint v, input int bits);
        longint m, r;
        m = longint'(1) << bits;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        for (int k = 0; k < N_CH; k++) begin
            ms0[k] = 0;
            ms1[k] = 0;
        end
        mCount = 0;
    endtask

    task automatic modelSample(input int x, output bit scalePt, output bit blockEnd);
        longint p, nxt;
        for (int k = 0; k < N_CH; k++) begin
            p      = wrapTo((ms0[k] * COEFF_VAL[k]) >>> (COEFF_BITS - 2), IW);
            nxt    = wrapTo(longint'(x) + p - ms1[k], IW);
            ms1[k] = ms0[k];
            ms0[k] = nxt;
        end
        mCount++;
        scalePt = (mCount % SCALE_LEN) == 0;
        if (scalePt) begin
            for (int k = 0; k < N_CH; k++) begin
                ms0[k] = ms0[k] >>> (SCALE_POW2 - 1);
                ms1[k] = ms1[k] >>> (SCALE_POW2 - 1);
            end
        end
        blockEnd = (mCount == BLOCK_LEN);
    endtask

    // One sample transaction, including the in_ready low window and count update.
    task automatic applyStimulus(input int x);
        int waitCycles, lowCycles, expLow;
        bit scalePt, blockEnd;
        waitCycles = 0;
        while (inReady !== 1'b1 && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("in_ready_idle", inReady, 1);
        inValid = 1'b1;
        inData  = DW'(x);
        @(posedge clk); #1;
        inValid = 1'b0;
        modelSample(x, scalePt, blockEnd);
        expLow = N_CH + (scalePt ? 1 : 0);
        lowCycles = 0;
        while (inReady === 1'b0 && outValid !== 1'b1 && lowCycles < 20) begin
            inValid = 1'($urandom_range(0, 1));
            inData  = DW'($urandom);
            @(posedge clk); #1;
            lowCycles++;
        end
        inValid = 1'b0;
        checkOutput("in_ready_low_cycles", lowCycles, expLow);
        if (blockEnd) checkOutput("out_valid_at_block_end", outValid, 1);
        else          checkOutput("count_o", countO, mCount);
    endtask

    task automatic runSamples(input int mode, input int num);
        int x, gap;
        for (int i = 0; i < num; i++) begin
            case (mode)
                0:       x = int'($urandom_range(0, 255)) - 128;
                1:       x = 127;
                2:       x = (i == 0) ? 64 : 0;
                default: x = int'($urandom_range(0, 8)) - 4;
            endcase
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk); #1;
            end
            applyStimulus(x);
        end
    endtask

    task automatic checkDumpWord(input int k, input int stall);
        checkOutput("dump_out_valid", outValid, 1);
        checkOutput("dump_out_ch", outCh, k);
        checkOutput("dump_out_s0", outS0, wrapTo(ms0[k], DW + 2));
        checkOutput("dump_out_s1", outS1, wrapTo(ms1[k], DW + 2));
        for (int i = 0; i < stall; i++) begin
            outReady = 1'b0;
            inValid  = 1'b1;
            inData   = DW'($urandom);
            @(posedge clk); #1;
            checkOutput("stall_out_ch", outCh, k);
            checkOutput("stall_out_s0", outS0, wrapTo(ms0[k], DW + 2));
            checkOutput("stall_out_s1", outS1, wrapTo(ms1[k], DW + 2));
            checkOutput("stall_in_ready", inReady, 0);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
    endtask

    task automatic dumpBlock(input int firstStall);
        for (int k = 0; k < N_CH; k++)
            checkDumpWord(k, (k == 0) ? firstStall : int'($urandom_range(0, 3)));
        checkOutput("post_dump_out_valid", outValid, 0);
        checkOutput("post_dump_count", countO, 0);
        checkOutput("post_dump_in_ready", inReady, 1);
        checkOutput("post_dump_out_s0", outS0, 0);
        modelClear();
    endtask

    initial begin
        int highSeen;
        rstN = 1'b0; clrI = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
        modelClear();
        #12;
        checkOutput("reset_in_ready", inReady, 1);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_out_ch", outCh, 0);
        checkOutput("reset_out_s0", outS0, 0);
        checkOutput("reset_out_s1", outS1, 0);
        checkOutput("reset_count", countO, 0);
        rstN = 1'b1;
        @(posedge clk); #1;

        $display("[TB] block 1: random samples, long stall on first dump word");
        runSamples(0, BLOCK_LEN);
        dumpBlock(5);

        $display("[TB] block 2: impulse response");
        runSamples(2, BLOCK_LEN);
        dumpBlock(int'($urandom_range(0, 3)));

        $display("[TB] block 3: constant full-scale input, wrapping states");
        runSamples(1, BLOCK_LEN);
        dumpBlock(int'($urandom_range(0, 3)));

        $display("[TB] block 4: clear during dump");
        runSamples(3, BLOCK_LEN);
        checkDumpWord(0, 1);
        checkOutput("dump_ch1_presented", outCh, 1);
        clrI = 1'b1;
        @(posedge clk); #1;
        clrI = 1'b0;
        checkOutput("clr_out_valid", outValid, 0);
        checkOutput("clr_in_ready", inReady, 1);
        checkOutput("clr_count", countO, 0);
        highSeen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (outValid !== 1'b0) highSeen++;
        end
        checkOutput("clr_no_ch1_word", highSeen, 0);
        modelClear();

        $display("[TB] block 5: clean block after clear");
        runSamples(0, BLOCK_LEN);
        dumpBlock(int'($urandom_range(0, 3)));

        $display("[TB] block 6: reset asserted mid-calculation");
        runSamples(0, 5);
        while (inReady !== 1'b1) begin
            @(posedge clk); #1;
        end
        inValid = 1'b1;
        inData  = DW'(100);
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("calc_in_ready_low", inReady, 0);
        rstN = 1'b0;
        #1;
        checkOutput("async_reset_in_ready", inReady, 1);
        checkOutput("async_reset_count", countO, 0);
        checkOutput("async_reset_out_valid", outValid, 0);
        checkOutput("async_reset_out_s0", outS0, 0);
        #3;
        rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_in_ready", inReady, 1);
        checkOutput("post_reset_count", countO, 0);
        modelClear();

        $display("[TB] block 7: clean block after reset");
        runSamples(0, BLOCK_LEN);
        dumpBlock(int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
